spi_reg_sequencer: RTL and testbench

// Sequences the host SPI link onto the internal register bus of the motor controller.

---
 rtl/bdc_pkg.sv | 37 +++
 rtl/spi_pin_sync.sv | 57 +++++
 rtl/spi_reg_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_reg_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bdc_pkg.sv
// Shared definitions for the SPI-to-register-bus sequencer.
//   seq_state_e : sequencer FSM states
//   CMD_*       : bit positions inside the command byte {rw, addr[3:0], 3'b000}
//   REG_*       : register map of the motor controller register file
//   make_cmd    : builds a command byte from rw flag and address
package bdc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    FETCH  = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } seq_state_e;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_LSB = 3;

  localparam logic [3:0] REG_PWM0 = 4'h0;
  localparam logic [3:0] REG_CFG  = 4'h2;
  localparam logic [3:0] REG_PWM1 = 4'h4;
  localparam logic [3:0] REG_PWM2 = 4'h8;
  localparam logic [3:0] REG_HWID = 4'hD;
  localparam logic [3:0] REG_WDIV = 4'hE;
  localparam logic [3:0] REG_WDOG = 4'hF;

  function automatic logic [7:0] make_cmd(input logic rw, input logic [3:0] addr);
    logic [7:0] c;
    c = '0;
    c[CMD_RW_BIT] = rw;
    c[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    return c;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Input conditioning for the SPI pins.
// Each of sclk/ss/mosi passes through SYNC_STAGES flops into the clk domain;
// one extra flop on sclk and ss gives single-cycle edge pulses.
//   clk_i, reset_i          : system clock, async active-high reset
//   sclk_i, ss_i, mosi_i    : raw SPI pins
//   sclk_rise_o/sclk_fall_o : one-clk pulses on synced sclk edges
//   ss_rise_o/ss_fall_o     : one-clk pulses on synced ss edges
//   ss_o, mosi_o            : synced levels
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sclk_i,
  input  logic ss_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic ss_rise_o,
  output logic ss_fall_o,
  output logic ss_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  // sclk and ss chains preset to 1: sclk idles high, and a slave select that
  // is already high at reset release must not look like a fresh ss rise.
  // The sequencer therefore only starts after ss is seen low, then high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_q      <= '1;
      ss_q        <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b1;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      ss_q        <= {ss_q[SYNC_STAGES-2:0], ss_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
  assign ss_rise_o   = ss_q[SYNC_STAGES-1] & ~ss_prev_q;
  assign ss_fall_o   = ~ss_q[SYNC_STAGES-1] & ss_prev_q;
  assign ss_o        = ss_q[SYNC_STAGES-1];
  assign mosi_o      = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_sequencer.sv
// Bridges the host SPI link (mode: sclk idle high, sample on rise, ss active
// high) onto the single-cycle register bus. Frames are {cmd, data}, MSB first.
//   clk, reset            : system clock, async active-high reset
//   sclk, ss, mosi        : SPI inputs (asynchronous to clk)
//   miso, spioe           : SPI read data and its pad output enable
//   reg_addr              : register address, held from cmd decode to frame end
//   reg_wdata, reg_we     : write data and one-clk write strobe
//   reg_re, reg_rdata     : one-clk read strobe, data RD_LATENCY clks later
//   frame_err             : one-clk pulse when a frame is cut short by ss
//
// state  | meaning
// IDLE   | waiting for synced ss rise
// CMD    | shifting command byte; address/rw latched on its last rise
// FETCH  | read strobe issued, waiting RD_LATENCY clks to load tx shifter
// DATA   | shifting data byte; tx shifter drives miso for reads
// COMMIT | issue write strobe (writes only)
// DONE   | frame complete; extra sclk ignored until ss drops
module spi_reg_sequencer
  import bdc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              spioe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int              CNT_W       = $clog2(2*DATA_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] BYTE2_FIRST = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(2*DATA_W - 1);
  localparam logic [1:0]       LAT_INIT    = 2'(RD_LATENCY);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_lvl, mosi_s;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk_i       (clk),
    .reset_i     (reset),
    .sclk_i      (sclk),
    .ss_i        (ss),
    .mosi_i      (mosi),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .ss_rise_o   (ss_rise),
    .ss_fall_o   (ss_fall),
    .ss_o        (ss_lvl),
    .mosi_o      (mosi_s)
  );

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [1:0]        lat_q, lat_d;
  logic              spioe_q, spioe_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              err_q, err_d;
  logic              in_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      lat_q   <= '0;
      spioe_q <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      lat_q   <= lat_d;
      spioe_q <= spioe_d;
      we_q    <= we_d;
      re_q    <= re_d;
      err_q   <= err_d;
    end
  end

  assign in_frame = (state_q == CMD) || (state_q == FETCH) || (state_q == DATA);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    lat_d   = lat_q;
    spioe_d = spioe_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = 1'b0;

    // One receive shifter serves both bytes; after the command byte it simply
    // keeps shifting, so it holds the data byte by the 16th rise.
    if (in_frame && sclk_rise) begin
      sh_d  = {sh_q[DATA_W-2:0], mosi_s};
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        spioe_d = 1'b0;
        cnt_d   = '0;
        if (ss_rise) begin
          state_d = CMD;
          sh_d    = '0;
        end
      end

      CMD: begin
        if (ss_fall) begin
          state_d = IDLE;
          spioe_d = 1'b0;
          err_d   = 1'b1;
        end else if (sclk_rise && (cnt_q == CMD_LAST)) begin
          addr_d = sh_d[CMD_ADDR_MSB -: ADDR_W];
          rw_d   = sh_d[CMD_RW_BIT];
          if (sh_d[CMD_RW_BIT]) begin
            state_d = FETCH;
            re_d    = 1'b1;
            lat_d   = LAT_INIT;
          end else begin
            state_d = DATA;
          end
        end
      end

      FETCH: begin
        // Down-counter reaches zero in the cycle reg_rdata is valid.
        if (ss_fall) begin
          state_d = IDLE;
          spioe_d = 1'b0;
          err_d   = 1'b1;
        end else if (lat_q == 2'd0) begin
          tx_d    = reg_rdata;
          spioe_d = 1'b1;
          state_d = DATA;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      DATA: begin
        // The 16th rise outranks a simultaneous ss fall.
        if (sclk_rise && (cnt_q == DATA_LAST)) begin
          state_d = COMMIT;
          spioe_d = 1'b0;
        end else if (ss_fall) begin
          state_d = IDLE;
          spioe_d = 1'b0;
          err_d   = 1'b1;
        end else if (sclk_fall && rw_q && (cnt_q >= BYTE2_FIRST)) begin
          // The fall between the two bytes must not consume the MSB.
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
      end

      COMMIT: begin
        if (!rw_q) begin
          we_d    = 1'b1;
          wdata_d = sh_q;
        end
        state_d = DONE;
      end

      DONE: begin
        // Level test: ss may already have dropped while committing.
        spioe_d = 1'b0;
        if (!ss_lvl) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        spioe_d = 1'b0;
      end
    endcase
  end

  assign miso      = spioe_q & tx_q[DATA_W-1];
  assign spioe     = spioe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
module tb_spi_reg_sequencer;
  import bdc_pkg::*;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b1;
  logic ss = 1'b0;
  logic mosi = 1'b0;

  logic       miso_a, spioe_a, we_a, re_a, err_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       miso_b, spioe_b, we_b, re_b, err_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_sequencer #(.SYNC_STAGES(2), .RD_LATENCY(1), .ADDR_W(4), .DATA_W(8)) dut_a (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso_a), .spioe(spioe_a), .reg_addr(addr_a), .reg_wdata(wdata_a),
    .reg_we(we_a), .reg_re(re_a), .reg_rdata(rdata_a), .frame_err(err_a)
  );

  spi_reg_sequencer #(.SYNC_STAGES(2), .RD_LATENCY(2), .ADDR_W(4), .DATA_W(8)) dut_b (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso_b), .spioe(spioe_b), .reg_addr(addr_b), .reg_wdata(wdata_b),
    .reg_we(we_b), .reg_re(re_b), .reg_rdata(rdata_b), .frame_err(err_b)
  );

  // Register file model: read data is valid only in the exact latency cycle,
  // the complement is driven otherwise so a latency slip is visible.
  logic [7:0] rd_val = 8'h00;
  logic re_a_d1 = 1'b0, re_b_d1 = 1'b0, re_b_d2 = 1'b0;
  always @(posedge clk) begin
    re_a_d1 <= re_a;
    re_b_d1 <= re_b;
    re_b_d2 <= re_b_d1;
  end
  assign rdata_a = re_a_d1 ? rd_val : ~rd_val;
  assign rdata_b = re_b_d2 ? rd_val : ~rd_val;

  // Strobe monitors
  int we_n_a = 0, re_n_a = 0, err_n_a = 0, we_n_b = 0, re_n_b = 0, err_n_b = 0, both_n = 0;
  logic [3:0] we_addr_a = '0, re_addr_a = '0, re_addr_b = '0;
  logic [7:0] we_data_a = '0;
  always @(negedge clk) begin
    if (we_a) begin we_n_a++; we_addr_a = addr_a; we_data_a = wdata_a; end
    if (re_a) begin re_n_a++; re_addr_a = addr_a; end
    if (err_a) err_n_a++;
    if (we_b) we_n_b++;
    if (re_b) begin re_n_b++; re_addr_b = addr_b; end
    if (err_b) err_n_b++;
    if ((we_a && re_a) || (we_b && re_b)) both_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: drive on fall, sample miso just before each rise.
  task automatic send_bits(input logic [15:0] w, input int n, input int gap_hi, input int gap_lo,
                           output logic [7:0] cap_a, output logic [7:0] cap_b, output int oe_bad);
    logic [15:0] sh;
    logic        rd;
    logic        exp_oe;
    int          lo, hi;
    sh = w;
    rd = w[15];
    cap_a = '0;
    cap_b = '0;
    oe_bad = 0;
    for (int i = 0; i < n; i++) begin
      lo = (i == 8) ? gap_lo : HALF;
      hi = (i == 7) ? gap_hi : HALF;
      sclk = 1'b0;
      mosi = (i < 16) ? sh[15] : 1'b0;
      sh = {sh[14:0], 1'b0};
      wait_clks(lo);
      exp_oe = rd && (i >= 8) && (i < 16);
      if (spioe_a !== exp_oe) oe_bad++;
      if (spioe_b !== exp_oe) oe_bad++;
      if ((i >= 8) && (i < 16)) begin
        cap_a = {cap_a[6:0], miso_a};
        cap_b = {cap_b[6:0], miso_b};
      end
      sclk = 1'b1;
      wait_clks(hi);
    end
  endtask

  task automatic frame(input logic [15:0] w, input int n, input int gap_hi, input int gap_lo,
                       output logic [7:0] cap_a, output logic [7:0] cap_b, output int oe_bad);
    ss = 1'b1;
    wait_clks(6);
    send_bits(w, n, gap_hi, gap_lo, cap_a, cap_b, oe_bad);
    wait_clks(HALF);
    ss = 1'b0;
    wait_clks(10);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] rd;
    int         exp_we;
    int         exp_re;
    logic [3:0] exp_addr;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] ca, cb;
    int oe_bad;
    int we0, re0, er0, web0, reb0, erb0;

    tbl[0] = '{cmd: make_cmd(1'b0, REG_CFG),  data: 8'h00, rd: 8'h00, exp_we: 1, exp_re: 0, exp_addr: 4'h2, exp_byte: 8'h00};
    tbl[1] = '{cmd: make_cmd(1'b0, REG_WDIV), data: 8'h10, rd: 8'h00, exp_we: 1, exp_re: 0, exp_addr: 4'hE, exp_byte: 8'h10};
    tbl[2] = '{cmd: make_cmd(1'b1, REG_HWID), data: 8'h00, rd: 8'hA5, exp_we: 0, exp_re: 1, exp_addr: 4'hD, exp_byte: 8'hA5};
    tbl[3] = '{cmd: 8'h03,                    data: 8'h3C, rd: 8'h00, exp_we: 1, exp_re: 0, exp_addr: 4'h0, exp_byte: 8'h3C};
    tbl[4] = '{cmd: 8'h90,                    data: 8'hFF, rd: 8'h5A, exp_we: 0, exp_re: 1, exp_addr: 4'h2, exp_byte: 8'h5A};

    // Reset state
    wait_clks(3);
    check("reset_outs_a", 32'({addr_a, wdata_a, we_a, re_a, err_a, spioe_a, miso_a}), 32'h0);
    check("reset_outs_b", 32'({addr_b, wdata_b, we_b, re_b, err_b, spioe_b, miso_b}), 32'h0);
    reset = 1'b0;
    wait_clks(6);

    // Table-driven frames
    foreach (tbl[v]) begin
      we0 = we_n_a; re0 = re_n_a; er0 = err_n_a; web0 = we_n_b; reb0 = re_n_b;
      rd_val = tbl[v].rd;
      frame({tbl[v].cmd, tbl[v].data}, 16, HALF, HALF, ca, cb, oe_bad);
      check("vec_we_cnt", 32'(we_n_a - we0), 32'(tbl[v].exp_we));
      check("vec_re_cnt", 32'(re_n_a - re0), 32'(tbl[v].exp_re));
      check("vec_we_cnt_b", 32'(we_n_b - web0), 32'(tbl[v].exp_we));
      check("vec_re_cnt_b", 32'(re_n_b - reb0), 32'(tbl[v].exp_re));
      check("vec_frame_err", 32'(err_n_a - er0), 32'h0);
      check("vec_spioe_window", 32'(oe_bad), 32'h0);
      check("vec_spioe_after", 32'({spioe_a, spioe_b}), 32'h0);
      if (tbl[v].exp_we != 0) begin
        check("vec_we_addr", 32'(we_addr_a), 32'(tbl[v].exp_addr));
        check("vec_wdata", 32'(we_data_a), 32'(tbl[v].exp_byte));
      end else begin
        check("vec_re_addr", 32'(re_addr_a), 32'(tbl[v].exp_addr));
        check("vec_miso_a", 32'(ca), 32'(tbl[v].exp_byte));
        check("vec_miso_b", 32'(cb), 32'(tbl[v].exp_byte));
      end
    end

    // Abort after 11 rises of a write to WDOG, then a clean write
    we0 = we_n_a; er0 = err_n_a; web0 = we_n_b; erb0 = err_n_b;
    frame({make_cmd(1'b0, REG_WDOG), 8'hAA}, 11, HALF, HALF, ca, cb, oe_bad);
    check("abort_no_we", 32'(we_n_a - we0), 32'h0);
    check("abort_no_we_b", 32'(we_n_b - web0), 32'h0);
    check("abort_err", 32'(err_n_a - er0), 32'h1);
    check("abort_err_b", 32'(err_n_b - erb0), 32'h1);
    we0 = we_n_a; er0 = err_n_a;
    frame({make_cmd(1'b0, REG_WDOG), 8'h0F}, 16, HALF, HALF, ca, cb, oe_bad);
    check("post_abort_we", 32'(we_n_a - we0), 32'h1);
    check("post_abort_addr", 32'(we_addr_a), 32'hF);
    check("post_abort_data", 32'(we_data_a), 32'h0F);
    check("post_abort_err", 32'(err_n_a - er0), 32'h0);

    // 24 sclk cycles in one write frame
    we0 = we_n_a; er0 = err_n_a; re0 = re_n_a;
    frame({make_cmd(1'b0, REG_PWM1), 8'hC0}, 24, HALF, HALF, ca, cb, oe_bad);
    check("long_we", 32'(we_n_a - we0), 32'h1);
    check("long_addr", 32'(we_addr_a), 32'h4);
    check("long_data", 32'(we_data_a), 32'hC0);
    check("long_err", 32'(err_n_a - er0), 32'h0);
    check("long_re", 32'(re_n_a - re0), 32'h0);

    // Reset mid-frame with ss held high
    we0 = we_n_a; er0 = err_n_a; re0 = re_n_a;
    ss = 1'b1;
    wait_clks(6);
    send_bits({make_cmd(1'b0, REG_PWM2), 8'h77}, 5, HALF, HALF, ca, cb, oe_bad);
    reset = 1'b1;
    #1;
    check("midrst_outs_a", 32'({addr_a, wdata_a, we_a, re_a, err_a, spioe_a, miso_a}), 32'h0);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(4);
    send_bits({make_cmd(1'b0, REG_PWM2), 8'h55}, 16, HALF, HALF, ca, cb, oe_bad);
    wait_clks(HALF);
    ss = 1'b0;
    wait_clks(10);
    check("midrst_no_we", 32'(we_n_a - we0), 32'h0);
    check("midrst_no_err", 32'(err_n_a - er0), 32'h0);
    frame({make_cmd(1'b0, REG_PWM2), 8'h77}, 16, HALF, HALF, ca, cb, oe_bad);
    check("midrst_then_we", 32'(we_n_a - we0), 32'h1);
    check("midrst_then_addr", 32'(we_addr_a), 32'h8);
    check("midrst_then_data", 32'(we_data_a), 32'h77);
    check("midrst_re", 32'(re_n_a - re0), 32'h0);

    // Back-to-back reads of WDOG with minimum inter-byte gap (7 clks)
    erb0 = err_n_b; reb0 = re_n_b;
    rd_val = 8'h3C;
    frame({make_cmd(1'b1, REG_WDOG), 8'h00}, 16, 4, 3, ca, cb, oe_bad);
    check("b2b_rd1_b", 32'(cb), 32'h3C);
    check("b2b_rd1_a", 32'(ca), 32'h3C);
    check("b2b_oe1", 32'(oe_bad), 32'h0);
    rd_val = 8'hC3;
    frame({make_cmd(1'b1, REG_WDOG), 8'h00}, 16, 4, 3, ca, cb, oe_bad);
    check("b2b_rd2_b", 32'(cb), 32'hC3);
    check("b2b_rd2_a", 32'(ca), 32'hC3);
    check("b2b_re_cnt", 32'(re_n_b - reb0), 32'h2);
    check("b2b_re_addr", 32'(re_addr_b), 32'hF);
    check("b2b_err", 32'(err_n_b - erb0), 32'h0);

    check("we_re_overlap", 32'(both_n), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
